// File: rtl/digit_editor.sv
// Purpose: debounces five push-buttons and edits an 8-digit value with a blinking cursor; DIGIT_EDITOR_BCD_EN makes digits BCD.
// Latency: ld takes effect on the next edge; a raw button edge reaches digits/cursor after 2 + DB_CYCLES + 1 edges.
// Backpressure: none; one action per cycle by priority ld > clr > up > down > left > right, the rest are dropped.
module digit_editor #(
    parameter int DB_CYCLES = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_clr,
    input  logic        ld,
    input  logic [31:0] ld_data,
    output logic [31:0] digits,
    output logic [2:0]  cursor,
    output logic [7:0]  dp,
    output logic        changed
);
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        ACT_NONE, ACT_LD, ACT_CLR, ACT_UP, ACT_DOWN, ACT_LEFT, ACT_RIGHT
    } act_t;

    // bit order: 4 clr, 3 up, 2 down, 1 left, 0 right
    logic [4:0]    raw, sync1, sync2, db, db_d, press;
    logic [DW-1:0] db_cnt [5];

    act_t          act;
    logic [3:0]    cur_dig;
    logic [31:0]   digits_nxt;
    logic [2:0]    cursor_nxt;
    logic          blink_rst;
    logic [BW-1:0] blink_cnt;
    logic          phase;

`ifdef DIGIT_EDITOR_BCD_EN
    function automatic logic [3:0] dig_sat(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction
    function automatic logic [3:0] dig_inc(input logic [3:0] d);
        return (dig_sat(d) == 4'd9) ? 4'd0 : dig_sat(d) + 4'd1;
    endfunction
    function automatic logic [3:0] dig_dec(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : dig_sat(d) - 4'd1;
    endfunction
    function automatic logic [31:0] load_val(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = dig_sat(v[i*4 +: 4]);
        return r;
    endfunction
`else
    function automatic logic [3:0] dig_inc(input logic [3:0] d);
        return d + 4'd1;
    endfunction
    function automatic logic [3:0] dig_dec(input logic [3:0] d);
        return d - 4'd1;
    endfunction
    function automatic logic [31:0] load_val(input logic [31:0] v);
        return v;
    endfunction
`endif

    assign raw = {btn_clr, btn_up, btn_down, btn_left, btn_right};

    // The level only moves after DB_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_d  <= db;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = db & ~db_d;

    always_comb begin
        act = ACT_NONE;
        if (ld)            act = ACT_LD;
        else if (press[4]) act = ACT_CLR;
        else if (press[3]) act = ACT_UP;
        else if (press[2]) act = ACT_DOWN;
        else if (press[1]) act = ACT_LEFT;
        else if (press[0]) act = ACT_RIGHT;
    end

    assign cur_dig = digits[{cursor, 2'b00} +: 4];

    always_comb begin
        digits_nxt = digits;
        cursor_nxt = cursor;
        blink_rst  = 1'b0;
        case (act)
            ACT_LD:    digits_nxt = load_val(ld_data);
            ACT_CLR: begin
                digits_nxt = '0;
                cursor_nxt = 3'd0;
                blink_rst  = 1'b1;
            end
            ACT_UP:    digits_nxt[{cursor, 2'b00} +: 4] = dig_inc(cur_dig);
            ACT_DOWN:  digits_nxt[{cursor, 2'b00} +: 4] = dig_dec(cur_dig);
            ACT_LEFT: begin
                cursor_nxt = cursor + 3'd1;
                blink_rst  = 1'b1;
            end
            ACT_RIGHT: begin
                cursor_nxt = cursor - 3'd1;
                blink_rst  = 1'b1;
            end
            default: ;
        endcase
    end

    // A cursor move restarts the blink in the lit phase so the new position shows at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits    <= '0;
            cursor    <= '0;
            changed   <= 1'b0;
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            digits  <= digits_nxt;
            cursor  <= cursor_nxt;
            changed <= (digits_nxt != digits);
            if (blink_rst) begin
                blink_cnt <= '0;
                phase     <= 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign dp = phase ? (8'h01 << cursor) : 8'h00;

endmodule

// File: tb/tb_digit_editor.sv
// Randomized bench for digit_editor: an event-level model queues expected digits/cursor states,
// a negedge monitor pops them on every observed change and also checks changed, dp and reset values.
module tb_digit_editor;
    localparam int DB = 4;
    localparam int BD = 8;
`ifdef DIGIT_EDITOR_BCD_EN
    localparam int RADIX = 10;
`else
    localparam int RADIX = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_clr = 1'b0;
    logic        ld = 1'b0;
    logic [31:0] ld_data = '0;
    logic [31:0] digits;
    logic [2:0]  cursor;
    logic [7:0]  dp;
    logic        changed;

    always #5 clk = ~clk;

    digit_editor #(.DB_CYCLES(DB), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_clr(btn_clr),
        .ld(ld), .ld_data(ld_data),
        .digits(digits), .cursor(cursor), .dp(dp), .changed(changed)
    );

    typedef struct packed {
        logic [31:0] dig;
        logic [2:0]  cur;
        logic        brst;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          ev_count = 0;
    int          last_ev_cyc = 0;
    int          blind_seq = 0;
    int          blind_seen = 0;
    logic [31:0] m_dig = '0;
    logic [2:0]  m_cur = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int dig_of(input logic [31:0] v, input int i);
        return int'((v >> (4 * i)) & 32'hF);
    endfunction

    function automatic logic [31:0] set_dig(input logic [31:0] v, input int i, input int d);
        logic [31:0] m;
        m = 32'hF << (4 * i);
        return (v & ~m) | ((32'(d) & 32'hF) << (4 * i));
    endfunction

    function automatic logic [31:0] bcd_sat(input logic [31:0] v);
        logic [31:0] r;
        r = v;
`ifdef DIGIT_EDITOR_BCD_EN
        for (int i = 0; i < 8; i++)
            if (dig_of(v, i) > 9) r = set_dig(r, i, 9);
`endif
        return r;
    endfunction

    // kind: 0 ld, 1 clr, 2 up, 3 down, 4 left, 5 right
    task automatic model_apply(input int kind, input logic [31:0] v);
        logic [31:0] nd;
        logic [2:0]  nc;
        logic        br;
        nd = m_dig;
        nc = m_cur;
        br = 1'b0;
        case (kind)
            0: nd = bcd_sat(v);
            1: begin nd = '0; nc = 3'd0; br = 1'b1; end
            2: nd = set_dig(m_dig, int'(m_cur), (dig_of(m_dig, int'(m_cur)) + 1) % RADIX);
            3: nd = set_dig(m_dig, int'(m_cur), (dig_of(m_dig, int'(m_cur)) + RADIX - 1) % RADIX);
            4: begin nc = m_cur + 3'd1; br = 1'b1; end
            default: begin nc = m_cur - 3'd1; br = 1'b1; end
        endcase
        if (nd != m_dig || nc != m_cur) expq.push_back('{dig: nd, cur: nc, brst: br});
        else if (br) blind_seq++;
        m_dig = nd;
        m_cur = nc;
    endtask

    function automatic int kind_of(input logic [4:0] m);
        if (m[4]) return 1;
        if (m[3]) return 2;
        if (m[2]) return 3;
        if (m[1]) return 4;
        return 5;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_btns(input logic [4:0] m);
        {btn_clr, btn_up, btn_down, btn_left, btn_right} = m;
    endtask

    task automatic do_press(input logic [4:0] m, input int hold);
        model_apply(kind_of(m), '0);
        set_btns(m);
        tick(hold);
        set_btns(5'b0);
        tick(DB + 8);
    endtask

    task automatic do_ld(input logic [31:0] v);
        model_apply(0, v);
        ld = 1'b1;
        ld_data = v;
        tick(1);
        ld = 1'b0;
        tick(3);
    endtask

    // Press, then check dp on the first cycles after the move lands.
    task automatic press_dp(input logic [4:0] m, input logic [7:0] exp_dp);
        int e0;
        e0 = ev_count;
        model_apply(kind_of(m), '0);
        set_btns(m);
        for (int i = 0; i < 40 && ev_count == e0; i++) tick(1);
        check("move_seen", ev_count != e0, 1);
        check("dp_after_move", dp, exp_dp);
        set_btns(5'b0);
        tick(DB + 8);
    endtask

    initial begin : monitor
        logic [31:0] pd;
        logic [2:0]  exp_cur;
        logic [7:0]  exp_dp;
        exp_t        e;
        int          n;
        int          t0;
        pd = '0;
        exp_cur = '0;
        n = 0;
        t0 = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_digits", digits, 32'h0);
                check("rst_cursor", cursor, 3'd0);
                check("rst_dp", dp, 8'h01);
                check("rst_changed", changed, 1'b0);
                t0 = n + 1;
                exp_cur = 3'd0;
                blind_seen = blind_seq;
                pd = '0;
            end else begin
                if (digits !== pd || cursor !== exp_cur) begin
                    check("event_expected", expq.size() > 0, 1);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        check("digits", digits, e.dig);
                        check("cursor", cursor, e.cur);
                        exp_cur = e.cur;
                        if (e.brst) begin
                            t0 = n;
                            blind_seen = blind_seq;
                        end
                    end
                    ev_count++;
                    last_ev_cyc = cyc;
                end
                check("changed", changed, digits !== pd);
                if (blind_seen == blind_seq) begin
                    exp_dp = (((n - t0) / BD) % 2 == 0) ? (8'h01 << exp_cur) : 8'h00;
                    check("dp", dp, exp_dp);
                end
                pd = digits;
            end
            n++;
        end
    end

    initial begin : stim
        int          p;
        int          r;
        logic [4:0]  m;
        logic [31:0] v;

        tick(3);
        rst = 1'b1;
        tick(20);
        check("idle_digits", digits, 32'h0);
        check("idle_cursor", cursor, 3'd0);

        do_ld(32'h1234_ABCF);
`ifdef DIGIT_EDITOR_BCD_EN
        check("ld_val", digits, 32'h1234_9999);
`else
        check("ld_val", digits, 32'h1234_ABCF);
`endif
        p = cyc;
        do_press(5'b01000, DB + 4);
        check("latency_min", last_ev_cyc - p >= 2 + DB + 1, 1);
        check("latency_max", last_ev_cyc - p <= 2 + DB + 3, 1);
`ifdef DIGIT_EDITOR_BCD_EN
        check("up_wrap", digits, 32'h1234_9990);
`else
        check("up_wrap", digits, 32'h1234_ABC0);
`endif
        do_press(5'b00100, DB + 4);
`ifdef DIGIT_EDITOR_BCD_EN
        check("down_wrap", digits, 32'h1234_9999);
`else
        check("down_wrap", digits, 32'h1234_ABCF);
`endif

        press_dp(5'b00001, 8'h80);
        check("right_wrap", cursor, 3'd7);
        press_dp(5'b00001, 8'h40);
        check("right_again", cursor, 3'd6);

        // glitch shorter than the debounce window, then a real hold
        btn_up = 1'b1;
        tick(2);
        btn_up = 1'b0;
        tick(DB + 6);
        do_press(5'b01000, 10);

        // ld, clr and up together: ld held across the window where the pulses land
        set_btns(5'b11000);
        tick(5);
        model_apply(0, 32'h0000_0005);
        ld = 1'b1;
        ld_data = 32'h0000_0005;
        tick(4);
        ld = 1'b0;
        tick(3);
        set_btns(5'b0);
        tick(DB + 8);
        check("prio_digits", digits, 32'h0000_0005);
        check("prio_cursor", cursor, 3'd6);

        do_press(5'b00010, DB + 3);
        do_press(5'b00010, DB + 3);
        check("left_wrap", cursor, 3'd0);
        do_ld(32'h0000_00FA);
`ifdef DIGIT_EDITOR_BCD_EN
        check("ld_sat", digits, 32'h0000_0099);
`else
        check("ld_sat", digits, 32'h0000_00FA);
`endif
        do_press(5'b01000, DB + 3);
`ifdef DIGIT_EDITOR_BCD_EN
        check("bcd_up", digits, 32'h0000_0090);
`else
        check("hex_up", digits, 32'h0000_00FB);
`endif

        // reset in the middle of a debounce discards the pending press
        btn_up = 1'b1;
        tick(3);
        rst = 1'b0;
        btn_up = 1'b0;
        expq.delete();
        m_dig = '0;
        m_cur = '0;
        tick(3);
        rst = 1'b1;
        tick(DB + 10);
        check("rst_mid_digits", digits, 32'h0);

        for (int it = 0; it < 70; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                do_ld($urandom());
            end else if (r == 1) begin
                do_ld(m_dig);
            end else if (r == 2) begin
                m = 5'b00001 << $urandom_range(0, 4);
                set_btns(m);
                tick(int'($urandom_range(1, DB - 2)));
                set_btns(5'b0);
                tick(DB + 6);
            end else begin
                if (r == 9) m = 5'($urandom_range(1, 31));
                else        m = 5'b00001 << $urandom_range(0, 4);
                do_press(m, int'($urandom_range(DB + 2, DB + 8)));
            end
        end

        tick(20);
        check("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/digit_editor.md
Name: digit_editor

Overview:
- Upstream input stage for the 8-digit seven-segment display path.
- Debounces five raw push-buttons and lets the user edit an 8-digit hex value with a cursor.
- Supports a parallel load of the whole value.
- Drives the digit nibbles and per-digit decimal-point (cursor blink) bits consumed by the display scan/mux stage.

Parameters:
- DB_CYCLES, 100000: number of consecutive stable synchronized samples required before a button's debounced level changes.
- BLINK_DIV, 25000000: clk cycles per half-period of the cursor blink.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- btn_up  input  1  raw button: increment the digit at the cursor.
- btn_down  input  1  raw button: decrement the digit at the cursor.
- btn_left  input  1  raw button: move the cursor one digit left (toward digit 7).
- btn_right  input  1  raw button: move the cursor one digit right (toward digit 0).
- btn_clr  input  1  raw button: clear all digits and home the cursor.
- ld  input  1  synchronous one-cycle load strobe.
- ld_data  input  32  value to load; digit i = bits [4i+3:4i].
- digits  output  32  current value; digit i = bits [4i+3:4i], digit 0 rightmost.
- cursor  output  3  current cursor digit index.
- dp  output  8  active-high decimal-point enables, one per digit.
- changed  output  1  one-cycle pulse whenever digits changes value.

Behaviour:
- Reset (rst=0, async):
  - digits=0, cursor=0, changed=0.
  - Blink counter=0, blink phase=1, so dp=8'h01.
  - All synchronizers, debounce counters and debounced levels cleared to 0.
  - Reset mid-debounce or mid-blink discards progress.
- Input conditioning, per button:
  - 2-flop synchronizer feeds a debounce counter.
  - Counter resets whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments; on reaching DB_CYCLES-1 the debounced level takes the synchronized level and the counter clears.
  - A 0->1 transition of the debounced level gives a 1-cycle press pulse.
  - Holding a button gives exactly one pulse; release gives none.
- Action priority, at most one action per cycle; lower-priority pulses in the same cycle are dropped, not queued:
  - ld > clr > up > down > left > right.
- Actions take effect on the clock edge after the pulse cycle (1-cycle registered latency):
  - ld: digits=ld_data; cursor unchanged.
  - clr: digits=0; cursor=0.
  - up: digit[cursor] = digit[cursor]+1 mod 16 (F->0). Other digits unchanged; no carry.
  - down: digit[cursor] = digit[cursor]-1 mod 16 (0->F). No borrow.
  - left: cursor=cursor+1, wrapping 7->0.
  - right: cursor=cursor-1, wrapping 0->7.
- changed:
  - Asserted in the cycle the new digits value first appears, only if the new value differs from the old.
  - ld of an identical value and clr of an all-zero value give no pulse.
- Blink:
  - Counter runs 0..BLINK_DIV-1; on wrap the blink phase toggles.
  - dp = phase ? (8'h01 << cursor) : 8'h00.
  - Any executed cursor-changing action (left, right, clr) clears the counter and forces phase=1, so the new cursor position is visible immediately.
- Latency, raw edge to digits update: 2 (sync) + DB_CYCLES (debounce) + 1 (edge detect) + 1 (action register) cycles, ±1 for sample alignment.

Optional Feature:
- Macro: DIGIT_EDITOR_BCD_EN.
- When defined:
  - up wraps 9->0; down wraps 0->9.
  - Any digit value >9, whether present or arriving on ld, is forced to 9 at load time.
  - digits is therefore always valid BCD.
- When undefined: full hex behaviour as above.

Test Plan (DB_CYCLES=4, BLINK_DIV=8):
- Reset, then release; no buttons pressed -> digits=0, cursor=0, dp toggles 8'h01/8'h00 every 8 cycles; changed never pulses.
- ld=1 with ld_data=32'h1234_ABCF, then up pulse with cursor=0 -> digits=32'h1234_ABC0, changed pulses once; then down -> 32'h1234_ABCF.
- Two right presses from cursor=0 -> cursor=7 then 6; dp=8'h80 then 8'h40 immediately after each move (blink forced on).
- 2-cycle glitch on btn_up, then 10-cycle hold -> glitch ignored; exactly one increment for the hold; no action on release.
- ld, btn_clr and btn_up pulses in the same cycle with ld_data=32'h0000_0005 -> digits=32'h0000_0005, cursor unchanged; clr and up dropped.
- With DIGIT_EDITOR_BCD_EN: ld 32'h0000_00FA -> digits=32'h0000_0099; up at cursor 0 -> 32'h0000_0090.
